imem_load_fetch_ctrl: RTL and testbench

Sequences the 16-bit instruction memory through two phases: program load, then instruction fetch. In the load phase it accepts program words over a valid/ready stream and drives the memory write port at consecutive addresses. In the run phase it owns the PC and drives the memory read address, honouring stall and redirect from the pipeline front end. It sits between the program loader / testbench source, the instruction memory, and the fetch stage.

---
 rtl/imem_ctrl_pkg.sv | 16 +
 rtl/imem_load_fetch_ctrl_fetch_pc_unit.sv | 45 ++++
 rtl/imem_load_fetch_ctrl.sv | 123 ++++++++++++
 tb/tb_imem_load_fetch_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_ctrl_pkg.sv
// rtl/imem_ctrl_pkg.sv - shared types and default widths for the imem load/fetch controller
package imem_ctrl_pkg;

   localparam int N_DEF      = 20;
   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 16;
   localparam logic [31:0] START_ADDR_DEF = 32'd0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_RUN   = 2'd2,
      ST_FAULT = 2'd3
   } state_t;

endpackage

// File: rtl/imem_load_fetch_ctrl_fetch_pc_unit.sv
// rtl/imem_load_fetch_ctrl_fetch_pc_unit.sv - pc register with redirect/stall/increment priority and bound check
module fetch_pc_unit
   import imem_ctrl_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(START_ADDR_DEF)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              active,
   input  logic              upd_en,
   input  logic              pc_init,
   input  logic              stall,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_addr,
   input  logic [N:0]        prog_len,
   output logic [ADDR_W-1:0] pc,
   output logic              fetch_valid,
   output logic              redir_fault
);

   logic [ADDR_W-1:0] len_ext;
   logic              in_bound;

   assign len_ext     = {{(ADDR_W-N-1){1'b0}}, prog_len};
   assign in_bound    = (pc < len_ext);
   assign fetch_valid = active & in_bound;
   assign redir_fault = upd_en & redirect & (redirect_addr >= len_ext);

   // Once pc reaches prog_len the increment stops, so pc parks there (DONE).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc <= START_ADDR;
      end else if (pc_init) begin
         pc <= START_ADDR;
      end else if (upd_en) begin
         if (redirect)
            pc <= redirect_addr;
         else if (!stall && in_bound)
            pc <= pc + 1'b1;
      end
   end

endmodule

// File: rtl/imem_load_fetch_ctrl.sv
// rtl/imem_load_fetch_ctrl.sv - program load then instruction fetch sequencing for the 16-bit imem
module imem_load_fetch_ctrl
   import imem_ctrl_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(START_ADDR_DEF)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              ld_valid,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_last,
   output logic              ld_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [ADDR_W-1:0] mem_raddr,
   input  logic              stall,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_addr,
   output logic [ADDR_W-1:0] pc,
   output logic              fetch_valid,
   output logic [N:0]        prog_len,
   output logic [1:0]        state_o,
   output logic              err
);

   state_t     state;
   logic [N-1:0] wr_ptr;
   logic       accept;
   logic       in_run;
   logic       run_upd;
   logic       pc_init;
   logic       redir_fault;

   assign ld_ready  = (state == ST_LOAD);
   assign accept    = ld_valid & ld_ready;
   assign mem_we    = accept;
   assign mem_waddr = {{(ADDR_W-N){1'b0}}, wr_ptr};
   assign mem_wdata = ld_data;
   assign mem_raddr = pc;
   assign state_o   = state;

   assign in_run  = (state == ST_RUN);
   // start outranks redirect, so a reload request freezes the pc path.
   assign run_upd = in_run & ~start;
   assign pc_init = accept & ld_last;

   fetch_pc_unit #(
      .N          (N),
      .ADDR_W     (ADDR_W),
      .START_ADDR (START_ADDR)
   ) u_pc (
      .clk           (clk),
      .rst           (rst),
      .active        (in_run),
      .upd_en        (run_upd),
      .pc_init       (pc_init),
      .stall         (stall),
      .redirect      (redirect),
      .redirect_addr (redirect_addr),
      .prog_len      (prog_len),
      .pc            (pc),
      .fetch_valid   (fetch_valid),
      .redir_fault   (redir_fault)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         wr_ptr   <= '0;
         prog_len <= '0;
         err      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state    <= ST_LOAD;
                  wr_ptr   <= '0;
                  prog_len <= '0;
               end
            end
            ST_LOAD: begin
               if (accept) begin
                  wr_ptr <= wr_ptr + 1'b1;
                  if (ld_last) begin
                     state    <= ST_RUN;
                     prog_len <= {1'b0, wr_ptr} + (N+1)'(1);
                  end else if (&wr_ptr) begin
                     // Final slot filled with no terminator: memory overflow.
                     state    <= ST_FAULT;
                     err      <= 1'b1;
                     prog_len <= (N+1)'(1) << N;
                  end
               end
            end
            ST_RUN: begin
               if (start) begin
                  state    <= ST_LOAD;
                  wr_ptr   <= '0;
                  prog_len <= '0;
               end else if (redir_fault) begin
                  state <= ST_FAULT;
                  err   <= 1'b1;
               end
            end
            ST_FAULT: begin
               if (start) begin
                  state    <= ST_LOAD;
                  wr_ptr   <= '0;
                  prog_len <= '0;
                  err      <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_load_fetch_ctrl.sv
// tb/tb_imem_load_fetch_ctrl.sv - directed self-checking bench for imem_load_fetch_ctrl
module tb_imem_load_fetch_ctrl;

   localparam int N = 3;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic              ld_valid = 1'b0;
   logic [DATA_W-1:0] ld_data = '0;
   logic              ld_last = 1'b0;
   logic              ld_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic [ADDR_W-1:0] mem_raddr;
   logic              stall = 1'b0;
   logic              redirect = 1'b0;
   logic [ADDR_W-1:0] redirect_addr = '0;
   logic [ADDR_W-1:0] pc;
   logic              fetch_valid;
   logic [N:0]        prog_len;
   logic [1:0]        state_o;
   logic              err;

   logic [DATA_W-1:0] mem [0:7];
   logic [DATA_W-1:0] rdata = '0;
   logic [DATA_W-1:0] exp_w [0:3];

   int errors = 0;
   int checks = 0;

   imem_load_fetch_ctrl #(.N(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .START_ADDR('0)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .ld_valid      (ld_valid),
      .ld_data       (ld_data),
      .ld_last       (ld_last),
      .ld_ready      (ld_ready),
      .mem_we        (mem_we),
      .mem_waddr     (mem_waddr),
      .mem_wdata     (mem_wdata),
      .mem_raddr     (mem_raddr),
      .stall         (stall),
      .redirect      (redirect),
      .redirect_addr (redirect_addr),
      .pc            (pc),
      .fetch_valid   (fetch_valid),
      .prog_len      (prog_len),
      .state_o       (state_o),
      .err           (err)
   );

   always #5 clk = ~clk;

   // Memory model: write on rising edge, read data presented on falling edge.
   always @(posedge clk) if (mem_we) mem[mem_waddr[2:0]] <= mem_wdata;
   always @(negedge clk) rdata <= mem[mem_raddr[2:0]];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_word(input logic [15:0] d, input logic last, input logic [2:0] addr, input string tag);
      ld_valid = 1'b1;
      ld_data  = d;
      ld_last  = last;
      #1;
      check({tag, "_we"}, 64'(mem_we), 64'd1);
      check({tag, "_waddr"}, 64'(mem_waddr), 64'(addr));
      step();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 8; i++) mem[i] = '0;
      exp_w[0] = 16'h1111; exp_w[1] = 16'h2222; exp_w[2] = 16'h3333; exp_w[3] = 16'h4444;

      // reset state
      step(); step();
      check("rst_state", 64'(state_o), 64'd0);
      check("rst_ready", 64'(ld_ready), 64'd0);
      check("rst_we", 64'(mem_we), 64'd0);
      check("rst_fv", 64'(fetch_valid), 64'd0);
      check("rst_len", 64'(prog_len), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_pc", 64'(pc), 64'd0);
      rst = 1'b1;
      step();

      // 1: asynchronous reset in the middle of a load
      start = 1'b1; step(); start = 1'b0;
      check("t1_state", 64'(state_o), 64'd1);
      load_word(16'hA001, 1'b0, 3'd0, "t1_w0");
      load_word(16'hA002, 1'b0, 3'd1, "t1_w1");
      load_word(16'hA003, 1'b0, 3'd2, "t1_w2");
      ld_valid = 1'b1; ld_data = 16'hA004;
      #2 rst = 1'b0;
      #1;
      check("t1_rst_state", 64'(state_o), 64'd0);
      check("t1_rst_ready", 64'(ld_ready), 64'd0);
      check("t1_rst_we", 64'(mem_we), 64'd0);
      check("t1_rst_len", 64'(prog_len), 64'd0);
      step();
      ld_valid = 1'b0;
      check("t1_mem0", 64'(mem[0]), 64'hA001);
      check("t1_mem1", 64'(mem[1]), 64'hA002);
      check("t1_mem2", 64'(mem[2]), 64'hA003);
      check("t1_mem3", 64'(mem[3]), 64'h0);
      rst = 1'b1;
      step();

      // 2: load four words with valid gaps
      start = 1'b1; step(); start = 1'b0;
      check("t2_ready", 64'(ld_ready), 64'd1);
      #1 check("t2_gap0_we", 64'(mem_we), 64'd0);
      step();
      load_word(16'h1111, 1'b0, 3'd0, "t2_w0");
      #1 check("t2_gap1_we", 64'(mem_we), 64'd0);
      step();
      load_word(16'h2222, 1'b0, 3'd1, "t2_w1");
      load_word(16'h3333, 1'b0, 3'd2, "t2_w2");
      #1 check("t2_gap2_we", 64'(mem_we), 64'd0);
      step();
      load_word(16'h4444, 1'b1, 3'd3, "t2_w3");
      check("t2_state", 64'(state_o), 64'd2);
      check("t2_len", 64'(prog_len), 64'd4);
      check("t2_pc", 64'(pc), 64'd0);
      check("t2_ready_off", 64'(ld_ready), 64'd0);
      check("t2_mem4", 64'(mem[4]), 64'h0);

      // 3: free-running fetch to DONE
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t3_pc%0d", i), 64'(pc), 64'(i));
         check($sformatf("t3_fv%0d", i), 64'(fetch_valid), 64'd1);
         @(negedge clk); #1;
         check($sformatf("t3_rd%0d", i), 64'(rdata), 64'(exp_w[i]));
         step();
      end
      check("t3_done_pc", 64'(pc), 64'd4);
      check("t3_done_fv", 64'(fetch_valid), 64'd0);
      step();
      check("t3_hold_pc", 64'(pc), 64'd4);
      check("t3_hold_fv", 64'(fetch_valid), 64'd0);
      check("t3_hold_state", 64'(state_o), 64'd2);

      // 4: stall holds pc; redirect beats stall
      redirect = 1'b1; redirect_addr = 32'd1; step(); redirect = 1'b0;
      check("t4_pc_redir", 64'(pc), 64'd1);
      stall = 1'b1;
      step(); check("t4_stall1", 64'(pc), 64'd1);
      step(); check("t4_stall2", 64'(pc), 64'd1);
      redirect = 1'b1; redirect_addr = 32'd3; step();
      redirect = 1'b0; stall = 1'b0;
      check("t4_pc_win", 64'(pc), 64'd3);
      check("t4_fv", 64'(fetch_valid), 64'd1);
      check("t4_state", 64'(state_o), 64'd2);

      // 5: out-of-range redirect faults, start recovers
      redirect = 1'b1; redirect_addr = 32'd7; step(); redirect = 1'b0;
      check("t5_state", 64'(state_o), 64'd3);
      check("t5_err", 64'(err), 64'd1);
      check("t5_fv", 64'(fetch_valid), 64'd0);
      check("t5_ready", 64'(ld_ready), 64'd0);
      start = 1'b1; step(); start = 1'b0;
      check("t5_reload_state", 64'(state_o), 64'd1);
      check("t5_reload_err", 64'(err), 64'd0);
      check("t5_reload_len", 64'(prog_len), 64'd0);

      // 6: fill all 2^N words without ld_last -> overflow fault
      for (int i = 0; i < 8; i++)
         load_word(16'hB000 + 16'(i), 1'b0, 3'(i), $sformatf("t6_w%0d", i));
      check("t6_state", 64'(state_o), 64'd3);
      check("t6_err", 64'(err), 64'd1);
      check("t6_len", 64'(prog_len), 64'd8);
      ld_valid = 1'b1; ld_data = 16'hDEAD;
      #1;
      check("t6_ready9", 64'(ld_ready), 64'd0);
      check("t6_we9", 64'(mem_we), 64'd0);
      step();
      ld_valid = 1'b0;
      for (int i = 0; i < 8; i++)
         check($sformatf("t6_mem%0d", i), 64'(mem[i]), 64'(16'hB000 + 16'(i)));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
